// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with majority-vote bit sampling,
// false-start rejection, framing-error detection and a first-word-fall-through
// receive FIFO with a valid/ready read port and overrun reporting.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 460800,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_done_tick,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_SAMP0 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SAMP1 = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC   = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_DIV - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer
  logic r_sync1;
  logic r_sync2;

  // Receiver state
  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [2:0]    r_bitIdx;
  logic [2:0]    w_bitIdxNext;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;
  logic          r_samp0;
  logic          r_samp1;
  logic          w_samp0Next;
  logic          w_samp1Next;
  logic          w_maj;
  logic          w_push;
  logic          w_frameErr;
  logic          w_overrun;

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_doneTick;
  logic          r_frameErr;
  logic          r_overrun;
  logic          w_pop;
  logic          w_room;

  assign rx_valid     = (r_count != '0);
  assign rx_data      = rx_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count   = r_count;
  assign rx_done_tick = r_doneTick;
  assign frame_err    = r_frameErr;
  assign overrun      = r_overrun;

  assign w_pop  = rx_valid & rx_ready;
  assign w_room = (r_count != DEPTH) | w_pop;

  // Two-flop synchronizer; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver next-state logic: bit timing, the three mid-bit samples,
  // majority decision and the frame outcome (push, overrun or framing error).
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt + 1'b1;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_samp0Next  = r_samp0;
    w_samp1Next  = r_samp1;
    w_push       = 1'b0;
    w_frameErr   = 1'b0;
    w_overrun    = 1'b0;
    w_maj        = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);

    if (r_cnt == CNT_SAMP0) begin
      w_samp0Next = r_sync2;
    end
    if (r_cnt == CNT_SAMP1) begin
      w_samp1Next = r_sync2;
    end

    case (r_state)
      S_IDLE: begin
        w_cntNext = '0;
        if (!r_sync2) begin
          w_stateNext = S_START;
        end
      end
      S_START: begin
        if ((r_cnt == CNT_DEC) && w_maj) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext  = S_DATA;
          w_cntNext    = '0;
          w_bitIdxNext = '0;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_DEC) begin
          w_shiftNext = {w_maj, r_shift[7:1]};
        end
        if (r_cnt == CNT_LAST) begin
          w_cntNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = S_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_DEC) begin
          w_cntNext = '0;
          if (w_maj) begin
            w_stateNext = S_IDLE;
            if (w_room) begin
              w_push = 1'b1;
            end else begin
              w_overrun = 1'b1;
            end
          end else begin
            w_stateNext = S_BREAK;
            w_frameErr  = 1'b1;
          end
        end
      end
      S_BREAK: begin
        w_cntNext = '0;
        if (r_sync2) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Receiver state register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_samp0  <= 1'b1;
      r_samp1  <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_samp0  <= w_samp0Next;
      r_samp1  <= w_samp1Next;
    end
  end

  // FIFO pointers, occupancy and the one-cycle status pulses, all registered
  // on the stop-bit decision edge so the pushed byte and its tick appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_doneTick <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_doneTick <= w_push;
      r_frameErr <= w_frameErr;
      r_overrun  <= w_overrun;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because rx_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven bench for uart_rx_fifo. Bytes expected
// to reach the FIFO are queued as they are sent and compared as they are popped.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_FREQ   = 50000000;
  localparam int BAUD_RATE  = 460800;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT_DIV    = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_DIV / 2;
  localparam int DEC_EDGE   = 3 + 9 * BIT_DIV + HALF + 2;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_done_tick;
  logic       frame_err;
  logic       overrun;
  logic [4:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int doneCnt = 0;
  int ferrCnt = 0;
  int ovrCnt = 0;
  int lastTickCount = -1;
  logic [7:0] expQ [$];

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
    .overrun(overrun),
    .fifo_count(fifo_count)
  );

  // 100 MHz bench clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends
  initial begin
    #(150000 * 10);
    $display("[TB] FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: counts status pulses, checks their exclusivity and drains the scoreboard on pops
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick | frame_err | overrun) begin
        checks++;
        if ((int'(rx_done_tick) + int'(frame_err) + int'(overrun)) > 1) begin
          errors++;
          $display("[TB] FAIL pulse_exclusive: done=%b ferr=%b ovr=%b, required at most one", rx_done_tick, frame_err, overrun);
        end
      end
      if (rx_done_tick) begin
        doneCnt++;
        lastTickCount = int'(fifo_count);
      end
      if (frame_err) ferrCnt++;
      if (overrun) ovrCnt++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pop: got %02h, scoreboard empty", rx_data);
        end else begin
          logic [7:0] exp;
          exp = expQ.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("[TB] FAIL pop_data: got %02h required %02h", rx_data, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopBit);
    tick();
    rx = 1'b0;
    repeat (BIT_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) tick();
    end
    rx = stopBit;
    repeat (BIT_DIV) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || fifo_count !== 5'd0 || rx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_fifo: valid=%b count=%0d data=%02h, required 0/0/00", rx_valid, fifo_count, rx_data);
    end
    checks++;
    if (rx_done_tick !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulses: done=%b ferr=%b ovr=%b, required 0", rx_done_tick, frame_err, overrun);
    end
    tick();
    reset = 1'b0;
    repeat (BIT_DIV) tick();
  endtask

  task automatic test_single();
    int d0, f0, o0;
    rx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL single_count_before: got %0d required 0", fifo_count);
    end
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
    expQ.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (doneCnt - d0 != 1 || ferrCnt != f0 || ovrCnt != o0) begin
      errors++;
      $display("[TB] FAIL single_pulses: done=%0d ferr=%0d ovr=%0d required 1/0/0", doneCnt - d0, ferrCnt - f0, ovrCnt - o0);
    end
    checks++;
    if (lastTickCount != 1) begin
      errors++;
      $display("[TB] FAIL single_count_at_tick: got %0d required 1", lastTickCount);
    end
    checks++;
    if (fifo_count !== 5'd0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL single_drained: count=%0d pending=%0d required 0/0", fifo_count, expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    rx_ready = 1'b0;
    d0 = doneCnt;
    expQ.push_back(8'hA3);
    expQ.push_back(8'h3C);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd2 || doneCnt - d0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: count=%0d ticks=%0d required 2/2", fifo_count, doneCnt - d0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin
      errors++;
      $display("[TB] FAIL b2b_head: valid=%b data=%02h required 1/a3", rx_valid, rx_data);
    end
    tick();
    rx_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: valid=%b pending=%0d required 0/0", rx_valid, expQ.size());
    end
  endtask

  task automatic test_glitch();
    int d0, f0, o0;
    rx_ready = 1'b1;
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
    tick();
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (2 * BIT_DIV) tick();
    @(negedge clk);
    checks++;
    if (doneCnt != d0 || ferrCnt != f0 || ovrCnt != o0 || fifo_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL glitch_quiet: done=%0d ferr=%0d ovr=%0d count=%0d required all 0", doneCnt - d0, ferrCnt - f0, ovrCnt - o0, fifo_count);
    end
    d0 = doneCnt;
    expQ.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (doneCnt - d0 != 1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL glitch_recover: ticks=%0d pending=%0d required 1/0", doneCnt - d0, expQ.size());
    end
  endtask

  task automatic test_frame_error();
    int d0, f0, o0;
    rx_ready = 1'b1;
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
    send_byte(8'hF0, 1'b0);
    repeat (3 * BIT_DIV) tick();
    rx = 1'b1;
    repeat (BIT_DIV) tick();
    @(negedge clk);
    checks++;
    if (ferrCnt - f0 != 1) begin
      errors++;
      $display("[TB] FAIL ferr_count: got %0d required 1", ferrCnt - f0);
    end
    checks++;
    if (doneCnt != d0 || ovrCnt != o0 || fifo_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL ferr_nopush: done=%0d ovr=%0d count=%0d required 0/0/0", doneCnt - d0, ovrCnt - o0, fifo_count);
    end
    d0 = doneCnt;
    expQ.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (doneCnt - d0 != 1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL ferr_recover: ticks=%0d pending=%0d required 1/0", doneCnt - d0, expQ.size());
    end
  endtask

  task automatic test_overrun();
    int d0, o0;
    rx_ready = 1'b0;
    d0 = doneCnt; o0 = ovrCnt;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      expQ.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    send_byte(8'h99, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (ovrCnt - o0 != 1 || doneCnt - d0 != FIFO_DEPTH) begin
      errors++;
      $display("[TB] FAIL ovr_pulses: ovr=%0d ticks=%0d required 1/16", ovrCnt - o0, doneCnt - d0);
    end
    checks++;
    if (fifo_count !== 5'd16 || rx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL ovr_full: count=%0d head=%02h required 16/00", fifo_count, rx_data);
    end
    tick();
    rx_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL ovr_drain: valid=%b pending=%0d required 0/0", rx_valid, expQ.size());
    end
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    int d0, o0;
    rx_ready = 1'b0;
    d0 = doneCnt; o0 = ovrCnt;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      expQ.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    expQ.push_back(8'h99);
    fork
      send_byte(8'h99, 1'b1);
      begin
        tick();
        repeat (DEC_EDGE - 1) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (ovrCnt != o0 || doneCnt - d0 != FIFO_DEPTH + 1) begin
      errors++;
      $display("[TB] FAIL fullpop_pulses: ovr=%0d ticks=%0d required 0/17", ovrCnt - o0, doneCnt - d0);
    end
    checks++;
    if (lastTickCount != FIFO_DEPTH || fifo_count !== 5'd16 || rx_data !== 8'h01) begin
      errors++;
      $display("[TB] FAIL fullpop_count: at_tick=%0d count=%0d head=%02h required 16/16/01", lastTickCount, fifo_count, rx_data);
    end
    tick();
    rx_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL fullpop_drain: valid=%b pending=%0d required 0/0", rx_valid, expQ.size());
    end
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0, o0;
    rx_ready = 1'b0;
    send_byte(8'h44, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL rst_mid_prefill: count=%0d required 1", fifo_count);
    end
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
    fork
      send_byte(8'h7E, 1'b1);
      begin
        tick();
        repeat (5 * BIT_DIV + HALF) tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || fifo_count !== 5'd0 || rx_data !== 8'h00 ||
            rx_done_tick !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rst_mid_outputs: valid=%b count=%0d data=%02h done=%b ferr=%b ovr=%b required all 0",
                   rx_valid, fifo_count, rx_data, rx_done_tick, frame_err, overrun);
        end
      end
    join
    repeat (2) tick();
    reset = 1'b0;
    repeat (BIT_DIV) tick();
    @(negedge clk);
    checks++;
    if (doneCnt != d0 || ferrCnt != f0 || ovrCnt != o0 || fifo_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_nopush: done=%0d ferr=%0d ovr=%0d count=%0d required all 0", doneCnt - d0, ferrCnt - f0, ovrCnt - o0, fifo_count);
    end
    rx_ready = 1'b1;
    expQ.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (doneCnt - d0 != 1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_recover: ticks=%0d pending=%0d required 1/0", doneCnt - d0, expQ.size());
    end
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
